// File: rtl/mic_dma_reader.sv
// Avalon-MM read-master DMA replaying per-channel mic regions from SDRAM onto a tagged valid/ready stream.
// Optional feature: define MIC_RD_LOOP_EN for continuous loop playback while start stays high.
module mic_dma_reader #(
  parameter int unsigned NUM_MIC_PAIRS = 5,
  parameter logic [31:0] REGION_STRIDE = 32'd7680000,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] AM_ADDR,
  output logic [2:0]  AM_BURSTCOUNT,
  output logic        AM_READ,
  output logic [3:0]  AM_BYTEENABLE,
  input  logic        AM_WAITREQUEST,
  input  logic [31:0] AM_READDATA,
  input  logic        AM_READDATAVALID,
  input  logic        start,
  input  logic [31:0] start_address,
  input  logic [31:0] number_samples,
  input  logic        half_way_ack,
  input  logic        end_ack,
  output logic        half_way_latch,
  output logic        end_latch,
  output logic        FINISHED,
  output logic [31:0] out_data,
  output logic [2:0]  out_channel,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam logic [2:0]  LAST_CH = 3'(NUM_MIC_PAIRS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    base_q, base_d;
  logic [31:0]    total_q, total_d;
  logic [31:0]    ptr_q [8];
  logic [31:0]    ptr_d [8];
  logic [2:0]     ch_q, ch_d;
  logic [31:0]    issued_q, issued_d;
  logic [31:0]    outcnt_q, outcnt_d;
  logic [2:0]     outch_q, outch_d;
  logic [CW-1:0]  pending_q, pending_d;
  logic [AW-1:0]  wr_q, wr_d;
  logic [AW-1:0]  rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           am_read_q, am_read_d;
  logic [31:0]    am_addr_q, am_addr_d;
  logic           hw_q, hw_d;
  logic           end_q, end_d;
  logic           fin_q, fin_d;
  logic [31:0]    fifo_mem [FIFO_DEPTH];

  logic accept, push, pop, hw_set, end_set;

  function automatic logic [2:0] next_ch(input logic [2:0] c);
    return (c == LAST_CH) ? 3'd0 : c + 3'd1;
  endfunction

  assign accept  = am_read_q & ~AM_WAITREQUEST;
  // Returns outside an active transfer belong to abandoned or foreign reads.
  assign push    = AM_READDATAVALID & ((state_q == S_ISSUE) | (state_q == S_DRAIN));
  assign pop     = out_valid & out_ready;
  assign hw_set  = pop & ((outcnt_q + 32'd1) == (total_q >> 1)) & ((total_q >> 1) != 32'd0);
  assign end_set = pop & ((outcnt_q + 32'd1) == total_q);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    total_d   = total_q;
    ptr_d     = ptr_q;
    ch_d      = ch_q;
    issued_d  = issued_q;
    outcnt_d  = outcnt_q;
    outch_d   = outch_q;
    wr_d      = wr_q + AW'(push);
    rd_d      = rd_q + AW'(pop);
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    pending_d = pending_q + CW'(accept) - CW'(push);
    am_read_d = 1'b0;
    am_addr_d = am_addr_q;
    hw_d      = half_way_ack ? 1'b0 : (hw_set ? 1'b1 : hw_q);
    end_d     = end_ack ? 1'b0 : (end_set ? 1'b1 : end_q);
    fin_d     = (state_q == S_FIN) & start;

    if (accept) begin
      ptr_d[ch_q] = ptr_q[ch_q] + 32'd4;
      ch_d        = next_ch(ch_q);
      issued_d    = issued_q + 32'd1;
    end
    if (pop) begin
      outcnt_d = outcnt_q + 32'd1;
      outch_d  = next_ch(outch_q);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = start_address;
          total_d = number_samples * 32'(NUM_MIC_PAIRS);
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        for (int i = 0; i < 8; i++) ptr_d[i] = base_q + REGION_STRIDE * 32'(i);
        issued_d  = 32'd0;
        outcnt_d  = 32'd0;
        ch_d      = 3'd0;
        outch_d   = 3'd0;
        pending_d = '0;
        state_d   = (total_q == 32'd0) ? S_FIN : S_ISSUE;
      end
      S_ISSUE: begin
        if (accept && ((issued_q + 32'd1) == total_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((pending_q == '0) && (cnt_q == '0) && (outcnt_q == total_q)) begin
`ifdef MIC_RD_LOOP_EN
          state_d = start ? S_SETUP : S_FIN;
`else
          state_d = S_FIN;
`endif
        end
      end
      S_FIN: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Request stage: a stalled request holds; otherwise issue only with FIFO credit left.
    if (state_q == S_ISSUE) begin
      if (am_read_q && AM_WAITREQUEST) begin
        am_read_d = 1'b1;
      end else if ((issued_d < total_q) &&
                   ((32'(pending_d) + 32'(cnt_d)) < 32'(FIFO_DEPTH))) begin
        am_read_d = 1'b1;
        am_addr_d = ptr_d[ch_d];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      ch_q      <= 3'd0;
      issued_q  <= 32'd0;
      outcnt_q  <= 32'd0;
      outch_q   <= 3'd0;
      pending_q <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      am_read_q <= 1'b0;
      am_addr_q <= 32'd0;
      hw_q      <= 1'b0;
      end_q     <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      issued_q  <= issued_d;
      outcnt_q  <= outcnt_d;
      outch_q   <= outch_d;
      pending_q <= pending_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      am_read_q <= am_read_d;
      am_addr_q <= am_addr_d;
      hw_q      <= hw_d;
      end_q     <= end_d;
      fin_q     <= fin_d;
    end
  end

  // Data-path registers carry no reset; their validity is tracked by the control state.
  always_ff @(posedge CLK) begin
    base_q  <= base_d;
    total_q <= total_d;
    ptr_q   <= ptr_d;
    if (push) fifo_mem[wr_q] <= AM_READDATA;
  end

  assign AM_ADDR        = am_addr_q;
  assign AM_READ        = am_read_q;
  assign AM_BURSTCOUNT  = 3'd1;
  assign AM_BYTEENABLE  = 4'hF;
  assign out_valid      = (cnt_q != '0);
  assign out_data       = out_valid ? fifo_mem[rd_q] : 32'd0;
  assign out_channel    = outch_q;
  assign half_way_latch = hw_q;
  assign end_latch      = end_q;
  assign FINISHED       = fin_q;

endmodule

// File: tb/tb_mic_dma_reader.sv
// Scoreboard bench for mic_dma_reader: Avalon slave model plus expected address/data queues.
module tb_mic_dma_reader;
  localparam int          NP     = 5;
  localparam logic [31:0] STRIDE = 32'd7680000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] AM_ADDR;
  logic [2:0]  AM_BURSTCOUNT;
  logic        AM_READ;
  logic [3:0]  AM_BYTEENABLE;
  logic        AM_WAITREQUEST = 1'b0;
  logic [31:0] AM_READDATA = 32'd0;
  logic        AM_READDATAVALID = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_address = 32'd0;
  logic [31:0] number_samples = 32'd0;
  logic        half_way_ack = 1'b0;
  logic        end_ack = 1'b0;
  logic        half_way_latch, end_latch, FINISHED;
  logic [31:0] out_data;
  logic [2:0]  out_channel;
  logic        out_valid;
  logic        out_ready = 1'b0;

  always #5 CLK = ~CLK;

  mic_dma_reader dut (
    .CLK(CLK), .RESET(RESET),
    .AM_ADDR(AM_ADDR), .AM_BURSTCOUNT(AM_BURSTCOUNT), .AM_READ(AM_READ),
    .AM_BYTEENABLE(AM_BYTEENABLE), .AM_WAITREQUEST(AM_WAITREQUEST),
    .AM_READDATA(AM_READDATA), .AM_READDATAVALID(AM_READDATAVALID),
    .start(start), .start_address(start_address), .number_samples(number_samples),
    .half_way_ack(half_way_ack), .end_ack(end_ack),
    .half_way_latch(half_way_latch), .end_latch(end_latch), .FINISHED(FINISHED),
    .out_data(out_data), .out_channel(out_channel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int n_reads = 0, n_pops = 0;
  int first_acc = 0, last_acc = 0;
  int lat = 1;
  int stall_on = 1, stall_left = 0;
  logic rdy = 1'b1;
  logic popped = 1'b0;
  logic ack_on_last = 1'b0;
  logic end_ack_hold = 1'b0;
  logic stalled_prev = 1'b0;
  logic [31:0] stall_addr = 32'd0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [2:0]  exp_ch_q[$];
  int          ret_t_q[$];
  logic [31:0] ret_d_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  task automatic load_exp(input logic [31:0] base, input int ns);
    logic [31:0] a;
    exp_addr_q.delete(); exp_data_q.delete(); exp_ch_q.delete();
    ret_t_q.delete(); ret_d_q.delete();
    for (int s = 0; s < ns; s++)
      for (int c = 0; c < NP; c++) begin
        a = base + STRIDE * 32'(c) + 32'(4 * s);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(mem_word(a));
        exp_ch_q.push_back(3'(c));
      end
    n_reads = 0; n_pops = 0;
    start_address = base; number_samples = 32'(ns);
  endtask

  // One clock: slave and consumer act at the falling edge, then step past the rising edge.
  task automatic run_cycle();
    logic        acc;
    logic [31:0] wa, wd;
    logic [2:0]  wc;
    @(negedge CLK);
    cyc++;
    AM_WAITREQUEST = AM_READ && (n_reads == stall_on) && (stall_left > 0);
    if (AM_WAITREQUEST) stall_left--;
    if (stalled_prev) begin
      checks++;
      if (AM_READ !== 1'b1 || AM_ADDR !== stall_addr)
        $display("FAIL stall_hold read=%0b addr=%h, required read=1 addr=%h", AM_READ, AM_ADDR, stall_addr);
      else passes++;
    end
    stalled_prev = AM_WAITREQUEST;
    stall_addr   = AM_ADDR;
    acc = AM_READ && !AM_WAITREQUEST;
    if (acc) begin
      n_reads++;
      if (n_reads == 1) first_acc = cyc;
      last_acc = cyc;
      checks++;
      if (exp_addr_q.size() == 0)
        $display("FAIL read_addr unexpected read at %h, no read required", AM_ADDR);
      else begin
        wa = exp_addr_q.pop_front();
        if (AM_ADDR !== wa) $display("FAIL read_addr got %h, required %h", AM_ADDR, wa);
        else passes++;
      end
      ret_t_q.push_back(cyc + lat);
      ret_d_q.push_back(mem_word(AM_ADDR));
    end
    if (ret_t_q.size() > 0 && ret_t_q[0] <= cyc) begin
      AM_READDATAVALID = 1'b1;
      AM_READDATA = ret_d_q.pop_front();
      void'(ret_t_q.pop_front());
    end else begin
      AM_READDATAVALID = 1'b0;
      AM_READDATA = 32'hDEAD_BEEF;
    end
    out_ready = rdy;
    end_ack = end_ack_hold || (ack_on_last && out_valid && rdy && exp_data_q.size() == 1);
    popped = 1'b0;
    if (out_valid && rdy) begin
      popped = 1'b1;
      n_pops++;
      checks++;
      if (exp_data_q.size() == 0)
        $display("FAIL out_word unexpected word %h ch %0d, none required", out_data, out_channel);
      else begin
        wd = exp_data_q.pop_front();
        wc = exp_ch_q.pop_front();
        if (out_data !== wd || out_channel !== wc)
          $display("FAIL out_word got %h ch %0d, required %h ch %0d", out_data, out_channel, wd, wc);
        else passes++;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic run_until_fin(input int budget, input string name);
    for (int i = 0; i < budget && FINISHED !== 1'b1; i++) run_cycle();
    checks++;
    if (FINISHED !== 1'b1) $display("FAIL %s_finished got %0b, required 1 within %0d cycles", name, FINISHED, budget);
    else passes++;
  endtask

  task automatic close_transfer();
    start = 1'b0;
    run_cycle();
    run_cycle();
    half_way_ack = 1'b1; end_ack_hold = 1'b1;
    run_cycle();
    half_way_ack = 1'b0; end_ack_hold = 1'b0;
    run_cycle();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(posedge CLK);
    #1;
    checks++; if (AM_READ !== 1'b0) $display("FAIL rst_am_read got %0b, required 0", AM_READ); else passes++;
    checks++; if (AM_ADDR !== 32'd0) $display("FAIL rst_am_addr got %h, required 0", AM_ADDR); else passes++;
    checks++; if (AM_BURSTCOUNT !== 3'd1) $display("FAIL rst_burst got %0d, required 1", AM_BURSTCOUNT); else passes++;
    checks++; if (AM_BYTEENABLE !== 4'hF) $display("FAIL rst_be got %h, required f", AM_BYTEENABLE); else passes++;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'd0 || out_channel !== 3'd0)
      $display("FAIL rst_out got v=%0b d=%h ch=%0d, required 0/0/0", out_valid, out_data, out_channel); else passes++;
    checks++; if ({half_way_latch, end_latch, FINISHED} !== 3'b000)
      $display("FAIL rst_flags got %b, required 000", {half_way_latch, end_latch, FINISHED}); else passes++;
  endtask

  task automatic test_basic();
    load_exp(32'h0000_1000, 2);
    rdy = 1'b1; lat = 1; stall_left = 0;
    start = 1'b1;
    run_cycle();
    checks++; if (AM_READ !== 1'b0) $display("FAIL basic_setup_read got %0b, required 0", AM_READ); else passes++;
    run_cycle();
    checks++; if (AM_READ !== 1'b0) $display("FAIL basic_k1_read got %0b, required 0", AM_READ); else passes++;
    run_cycle();
    checks++; if (AM_READ !== 1'b1 || AM_ADDR !== 32'h1000)
      $display("FAIL basic_first_read got read=%0b addr=%h, required 1 / 00001000", AM_READ, AM_ADDR); else passes++;
    for (int i = 0; i < 60 && FINISHED !== 1'b1; i++) begin
      run_cycle();
      if (popped && n_pops == 4) begin
        checks++; if (half_way_latch !== 1'b0) $display("FAIL basic_half_early got %0b, required 0", half_way_latch); else passes++;
      end
      if (popped && n_pops == 5) begin
        checks++; if (half_way_latch !== 1'b1) $display("FAIL basic_half got %0b, required 1", half_way_latch); else passes++;
      end
      if (popped && n_pops == 9) begin
        checks++; if (end_latch !== 1'b0) $display("FAIL basic_end_early got %0b, required 0", end_latch); else passes++;
      end
      if (popped && n_pops == 10) begin
        checks++; if (end_latch !== 1'b1) $display("FAIL basic_end got %0b, required 1", end_latch); else passes++;
      end
    end
    checks++; if (FINISHED !== 1'b1) $display("FAIL basic_finished got %0b, required 1", FINISHED); else passes++;
    checks++; if (n_reads != 10 || n_pops != 10) $display("FAIL basic_counts got reads=%0d pops=%0d, required 10/10", n_reads, n_pops); else passes++;
    checks++; if (last_acc - first_acc != 9) $display("FAIL basic_back_to_back got span %0d, required 9", last_acc - first_acc); else passes++;
    start = 1'b0;
    run_cycle(); run_cycle();
    checks++; if (FINISHED !== 1'b0 || end_latch !== 1'b1)
      $display("FAIL basic_idle got fin=%0b end=%0b, required 0/1", FINISHED, end_latch); else passes++;
    close_transfer();
    checks++; if ({half_way_latch, end_latch} !== 2'b00)
      $display("FAIL basic_ack got %b, required 00", {half_way_latch, end_latch}); else passes++;
  endtask

  task automatic test_stall();
    load_exp(32'h0000_2000, 2);
    rdy = 1'b1; lat = 1; stall_on = 1; stall_left = 3;
    start = 1'b1;
    run_until_fin(80, "stall");
    checks++; if (n_reads != 10 || exp_addr_q.size() != 0 || stall_left != 0)
      $display("FAIL stall_reads got reads=%0d left=%0d stall_left=%0d, required 10/0/0", n_reads, exp_addr_q.size(), stall_left); else passes++;
    close_transfer();
  endtask

  task automatic test_backpressure();
    load_exp(32'h0000_3000, 2);
    rdy = 1'b0; lat = 1; stall_left = 0;
    start = 1'b1;
    repeat (30) run_cycle();
    checks++; if (n_reads != 8) $display("FAIL bp_reads got %0d, required 8", n_reads); else passes++;
    checks++; if (AM_READ !== 1'b0) $display("FAIL bp_read_idle got %0b, required 0", AM_READ); else passes++;
    checks++; if (out_valid !== 1'b1 || out_data !== exp_data_q[0] || n_pops != 0)
      $display("FAIL bp_head got v=%0b d=%h pops=%0d, required 1 %h 0", out_valid, out_data, n_pops, exp_data_q[0]); else passes++;
    rdy = 1'b1;
    run_until_fin(80, "bp");
    checks++; if (n_reads != 10 || n_pops != 10) $display("FAIL bp_counts got reads=%0d pops=%0d, required 10/10", n_reads, n_pops); else passes++;
    close_transfer();
  endtask

  task automatic test_empty();
    load_exp(32'h0000_4000, 0);
    rdy = 1'b1;
    start = 1'b1;
    run_cycle();
    run_cycle();
    checks++; if (FINISHED !== 1'b0) $display("FAIL empty_fin_early got %0b, required 0", FINISHED); else passes++;
    run_cycle();
    checks++; if (FINISHED !== 1'b1) $display("FAIL empty_fin got %0b, required 1", FINISHED); else passes++;
    checks++; if ({half_way_latch, end_latch, AM_READ} !== 3'b000 || n_reads != 0)
      $display("FAIL empty_quiet got flags %b reads=%0d, required 000/0", {half_way_latch, end_latch, AM_READ}, n_reads); else passes++;
    start = 1'b0;
    run_cycle(); run_cycle();
    checks++; if (FINISHED !== 1'b0) $display("FAIL empty_idle got %0b, required 0", FINISHED); else passes++;
  endtask

  task automatic test_ack_priority();
    load_exp(32'h0000_5000, 1);
    rdy = 1'b1; lat = 1; stall_left = 0;
    ack_on_last = 1'b1;
    start = 1'b1;
    run_until_fin(60, "ack");
    ack_on_last = 1'b0;
    checks++; if (end_latch !== 1'b0 || half_way_latch !== 1'b1 || n_pops != 5)
      $display("FAIL ack_priority got end=%0b half=%0b pops=%0d, required 0/1/5", end_latch, half_way_latch, n_pops); else passes++;
    start = 1'b0;
    run_cycle(); run_cycle();
    checks++; if (half_way_latch !== 1'b1) $display("FAIL ack_half_sticky got %0b, required 1", half_way_latch); else passes++;
    half_way_ack = 1'b1;
    run_cycle();
    half_way_ack = 1'b0;
    checks++; if (half_way_latch !== 1'b0) $display("FAIL ack_half_clear got %0b, required 0", half_way_latch); else passes++;
  endtask

  task automatic test_reset_mid();
    load_exp(32'h0000_6000, 4);
    rdy = 1'b1; lat = 1; stall_left = 0;
    start = 1'b1;
    for (int i = 0; i < 40 && n_pops < 4; i++) run_cycle();
    checks++; if (n_pops != 4) $display("FAIL rmid_pops got %0d, required 4", n_pops); else passes++;
    RESET = 1'b1; start = 1'b0; rdy = 1'b0;
    run_cycle();
    checks++; if (AM_READ !== 1'b0 || AM_ADDR !== 32'd0)
      $display("FAIL rmid_am got read=%0b addr=%h, required 0/0", AM_READ, AM_ADDR); else passes++;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'd0 || out_channel !== 3'd0)
      $display("FAIL rmid_out got v=%0b d=%h ch=%0d, required 0/0/0", out_valid, out_data, out_channel); else passes++;
    checks++; if ({half_way_latch, end_latch, FINISHED} !== 3'b000)
      $display("FAIL rmid_flags got %b, required 000", {half_way_latch, end_latch, FINISHED}); else passes++;
    RESET = 1'b0;
    ret_t_q.delete(); ret_d_q.delete();
    AM_WAITREQUEST = 1'b0;
    AM_READDATAVALID = 1'b1; AM_READDATA = 32'h1234_5678;
    @(posedge CLK);
    #1 AM_READDATAVALID = 1'b0;
    @(posedge CLK);
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'd0)
      $display("FAIL rmid_stray got v=%0b d=%h, required 0/0", out_valid, out_data); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_backpressure();
    test_empty();
    test_ack_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish, required finish before 200000");
    $fatal(1);
  end
endmodule
